muldiv_ctrl: RTL

// - Sequencing controller for the RV32M multiply/divide path. Replaces the ALU's single-cycle combinational MUL/DIV/REM.
// - MUL* ops use a registered single-cycle product. DIV/REM ops use an iterative restoring divider.
// - Sits beside the ALU in the execute stage. busy stalls the core until the result is accepted.
// - Implements the RISC-V-defined results for divide-by-zero and signed overflow.

---
 rtl/muldiv_pkg.sv | 19 +
 rtl/muldiv_ctrl_if.sv | 23 ++
 rtl/muldiv_ctrl_div_step.sv | 15 +
 rtl/muldiv_ctrl.sv | 105 ++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op codes, FSM states and constants for the RV32M multiply/divide controller.
package muldiv_pkg;
    localparam int MD_XLEN = 32;
    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL  = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [MD_XLEN-1:0] DIV0_Q  = '1;
    localparam logic [MD_XLEN-1:0] INT_MIN = {1'b1, {(MD_XLEN-1){1'b0}}};
endpackage

// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: request/response handshake bundle between the execute stage and muldiv_ctrl.
interface muldiv_ctrl_if #(parameter int XLEN = 32, parameter int TAG_W = 5);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [XLEN-1:0]  req_a;
    logic [XLEN-1:0]  req_b;
    logic [TAG_W-1:0] req_tag;
    logic             flush;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [XLEN-1:0]  rsp_result;
    logic [TAG_W-1:0] rsp_tag;
    logic             busy;
    modport slave (
        input  req_valid, req_op, req_a, req_b, req_tag, flush, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_tag, busy
    );
    modport master (
        output req_valid, req_op, req_a, req_b, req_tag, flush, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_tag, busy
    );
endinterface

// File: rtl/muldiv_ctrl_div_step.sv
// div_step: one combinational restoring-division iteration, shifting the next dividend bit into rem.
module div_step #(parameter int W = 32) (
    input  logic [W-1:0] rem_in,
    input  logic [W-1:0] q_in,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_out,
    output logic [W-1:0] q_out
);
    logic [W:0] w_t, w_d;
    assign w_t = {rem_in, q_in[W-1]};
    // rem < divisor always holds, so a borrow out of w_d means the trial subtraction failed
    assign w_d = w_t - {1'b0, divisor};
    assign rem_out = w_d[W] ? w_t[W-1:0] : w_d[W-1:0];
    assign q_out = {q_in[W-2:0], ~w_d[W]};
endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: RV32M sequencer; single-cycle registered multiply, iterative restoring divide,
// RISC-V divide-by-zero/overflow results, valid/ready response with flush.
module muldiv_ctrl import muldiv_pkg::*; #(
    parameter int XLEN   = MD_XLEN,
    parameter int UNROLL = 1,
    parameter int TAG_W  = 5
) (
    input logic clk,
    input logic rst,
    muldiv_ctrl_if.slave md
);
    localparam int CW = $clog2(XLEN / UNROLL);
    localparam logic [XLEN-1:0] L_ONES = '1;
    localparam logic [XLEN-1:0] L_MIN = {1'b1, {(XLEN-1){1'b0}}};
    logic [2:0]        r_state, r_op;
    logic [XLEN-1:0]   r_a, r_b, r_rem, r_q, r_result;
    logic [TAG_W-1:0]  r_tag;
    logic [CW-1:0]     r_cnt;
    logic              r_qneg, r_rneg;
    logic              w_sgn, w_div0, w_ovf, w_a_neg, w_b_neg;
    logic [XLEN-1:0]   w_abs_a, w_abs_b, w_special, w_mul_res, w_fix_res;
    logic [2*XLEN-1:0] w_ax, w_bx, w_prod;
    logic [XLEN-1:0]   w_rem [UNROLL+1];
    logic [XLEN-1:0]   w_q [UNROLL+1];
    assign md.req_ready  = (r_state == S_IDLE) && !md.flush;
    assign md.rsp_valid  = r_state == S_DONE;
    assign md.busy       = r_state != S_IDLE;
    assign md.rsp_result = r_result;
    assign md.rsp_tag    = r_tag;
    // op[0]==0 selects the signed DIV/REM among the divide ops
    assign w_sgn     = !md.req_op[0];
    assign w_div0    = md.req_b == '0;
    assign w_ovf     = w_sgn && md.req_a == L_MIN && md.req_b == L_ONES;
    assign w_a_neg   = w_sgn && md.req_a[XLEN-1];
    assign w_b_neg   = w_sgn && md.req_b[XLEN-1];
    assign w_abs_a   = w_a_neg ? -md.req_a : md.req_a;
    assign w_abs_b   = w_b_neg ? -md.req_b : md.req_b;
    assign w_special = w_div0 ? (md.req_op[1] ? md.req_a : L_ONES) : (md.req_op[1] ? '0 : md.req_a);
    // Modulo-2^(2*XLEN) product of the extended operands yields the exact high half
    assign w_ax      = {{XLEN{r_op != MD_MULHU && r_a[XLEN-1]}}, r_a};
    assign w_bx      = {{XLEN{(r_op == MD_MUL || r_op == MD_MULH) && r_b[XLEN-1]}}, r_b};
    assign w_prod    = w_ax * w_bx;
    assign w_mul_res = r_op == MD_MUL ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    assign w_fix_res = r_op[1] ? (r_rneg ? -r_rem : r_rem) : (r_qneg ? -r_q : r_q);
    assign w_rem[0]  = r_rem;
    assign w_q[0]    = r_q;
    for (genvar i = 0; i < UNROLL; i++) begin : g_step
        div_step #(.W(XLEN)) u_step (
            .rem_in(w_rem[i]), .q_in(w_q[i]), .divisor(r_b),
            .rem_out(w_rem[i+1]), .q_out(w_q[i+1])
        );
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_rem    <= '0;
            r_q      <= '0;
            r_result <= '0;
            r_tag    <= '0;
            r_cnt    <= '0;
            r_qneg   <= 1'b0;
            r_rneg   <= 1'b0;
        end else if (md.flush) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (md.req_valid) begin
                    r_op   <= md.req_op;
                    r_tag  <= md.req_tag;
                    r_a    <= md.req_a;
                    r_b    <= md.req_op[2] ? w_abs_b : md.req_b;
                    r_rem  <= '0;
                    r_q    <= w_abs_a;
                    r_cnt  <= CW'(XLEN / UNROLL - 1);
                    r_qneg <= w_a_neg ^ w_b_neg;
                    r_rneg <= w_a_neg;
                    if (!md.req_op[2]) r_state <= S_MUL;
                    else if (w_div0 || w_ovf) begin
                        r_result <= w_special;
                        r_state  <= S_DONE;
                    end else r_state <= S_DIV;
                end
                S_MUL: begin
                    r_result <= w_mul_res;
                    r_state  <= S_DONE;
                end
                S_DIV: begin
                    r_rem <= w_rem[UNROLL];
                    r_q   <= w_q[UNROLL];
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) r_state <= S_FIX;
                end
                S_FIX: begin
                    r_result <= w_fix_res;
                    r_state  <= S_DONE;
                end
                S_DONE: if (md.rsp_ready) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
